// File: rtl/sgd_x_rd_pkg.sv
// Shared definitions for the x-model read path: bank/chunk geometry,
// credit limits, the default BRAM read latency and the reader state encoding.
package sgd_x_rd_pkg;

    // Bank and engine geometry; one chunk covers 2^CHUNK_SHIFT model features.
    localparam int NUM_BITS_PER_BANK  = 8;
    localparam int NUM_OF_BANKS       = 8;
    localparam int BIT_WIDTH_OF_BANK  = 3;
    localparam int ENGINE_NUM_WIDTH   = 6;
    localparam int DIS_X_BIT_DEPTH    = 12;
    localparam int MAX_BIT_WIDTH_OF_X = 20;

    localparam int X_DATA_W    = NUM_BITS_PER_BANK * 32;
    localparam int CHUNK_SHIFT = BIT_WIDTH_OF_BANK + ENGINE_NUM_WIDTH;
    localparam int MC_W        = 12;

    // x BRAM read latency in cycles from x_rd_en to x_rd_data.
    localparam int RD_LATENCY_DEF = 2;

    // More outstanding credit than this means the writer counter ran away.
    localparam logic [7:0] CREDIT_MAX = 8'd128;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START       = 3'd1,
        EPOCH       = 3'd2,
        WAIT_CREDIT = 3'd3,
        ISSUE       = 3'd4,
        GROUP_END   = 3'd5,
        FINISH      = 3'd6
    } x_rd_state_e;

    // Credits available; modulo-256 subtraction keeps the count right across wrap.
    function automatic logic [7:0] credit_avail(input logic [7:0] credit,
                                                input logic [7:0] consumed);
        return credit - consumed;
    endfunction

endpackage

// File: rtl/sgd_valid_pipe.sv
// Control delay line that carries valid/last alongside the BRAM read latency.
// Every stage is cleared by reset so that nothing in flight survives it.
module sgd_valid_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift the control bits one stage per cycle; reset flushes the whole line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sgd_x_rd.sv
// Model (x) reader for the SGD engine: walks epochs and sample groups, waits
// for writer credits, issues one BRAM read per model chunk and returns the
// chunks with a last marker. Optional debug ports: define SGD_X_RD_DEBUG_EN.
module sgd_x_rd
    import sgd_x_rd_pkg::*;
#(
    parameter int RD_LATENCY         = RD_LATENCY_DEF,
    parameter int MAX_DIMENSION_BITS = MAX_BIT_WIDTH_OF_X
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       started,
    input  logic [31:0]                dimension,
    input  logic [31:0]                number_of_epochs,
    input  logic [31:0]                number_of_samples,
    input  logic [31:0]                mini_batch_size,
    input  logic [7:0]                 x_wr_credit_counter,
    input  logic                       x_rd_afull,
    output logic                       x_rd_en,
    output logic [DIS_X_BIT_DEPTH-1:0] x_rd_addr,
    input  logic [X_DATA_W-1:0]        x_rd_data,
    output logic                       x_out_valid,
    output logic [X_DATA_W-1:0]        x_out_data,
    output logic                       x_out_last,
    output logic                       x_rd_done,
    output logic                       x_rd_error
`ifdef SGD_X_RD_DEBUG_EN
    ,
    output logic [31:0]                state_counters_x_rd,
    output logic [31:0]                x_rd_counter
`endif
);

    x_rd_state_e          state_q;
    logic                 started_d1_q, started_d2_q;
    logic [MC_W-1:0]      main_counter_q, main_counter_d;
    logic [31:0]          epochs_q, samples_q, mini_batch_q;
    logic [31:0]          epoch_index_q, sample_index_q, sample_index_d;
    logic [7:0]           consumed_q, avail_d;
    logic [MC_W-1:0]      chunk_q;
    logic                 last_chunk_d, issue_d;
    logic                 x_rd_en_q, rd_last_q, done_q, error_q;
    logic [DIS_X_BIT_DEPTH-1:0] x_rd_addr_q;
    logic [X_DATA_W-1:0]  x_out_data_q;
    logic [1:0]           pipe_out;
    logic [MAX_DIMENSION_BITS:0] dim_sum_d;
    logic                 cfg_unused;

    // Chunks per sample group, rounded up; only the low dimension bits matter.
    assign dim_sum_d = {1'b0, dimension[MAX_DIMENSION_BITS-1:0]}
                     + (MAX_DIMENSION_BITS+1)'((1 << CHUNK_SHIFT) - 1);
    assign main_counter_d = MC_W'(dim_sum_d >> CHUNK_SHIFT);

    assign avail_d        = credit_avail(x_wr_credit_counter, consumed_q);
    assign sample_index_d = sample_index_q + 32'(NUM_OF_BANKS);
    assign last_chunk_d   = (chunk_q == main_counter_q - 1'b1);
    assign issue_d        = (state_q == ISSUE) && !x_rd_afull;

    // Mini-batch size and dimension bits above the model range do not affect reads.
    assign cfg_unused = ^{mini_batch_q, dimension[31:MAX_DIMENSION_BITS]};

    // Two-flop delay on the start level before leaving IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            started_d1_q <= 1'b0;
            started_d2_q <= 1'b0;
        end else begin
            started_d1_q <= started;
            started_d2_q <= started_d1_q;
        end
    end

    // Capture the job configuration once, as the reader leaves IDLE.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && started_d2_q) begin
            main_counter_q <= main_counter_d;
            epochs_q       <= number_of_epochs;
            samples_q      <= number_of_samples;
            mini_batch_q   <= mini_batch_size;
        end
    end

    // Reader state machine with registered strobe, last, done and error outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            x_rd_en_q      <= 1'b0;
            rd_last_q      <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            consumed_q     <= '0;
            epoch_index_q  <= '0;
            sample_index_q <= '0;
            chunk_q        <= '0;
        end else begin
            x_rd_en_q <= 1'b0;
            rd_last_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (started_d2_q) state_q <= START;
                end
                START: begin
                    epoch_index_q  <= '0;
                    sample_index_q <= '0;
                    consumed_q     <= '0;
                    if (main_counter_q == '0) begin
                        error_q <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        error_q <= 1'b0;
                        state_q <= EPOCH;
                    end
                end
                EPOCH: begin
                    if (epoch_index_q == epochs_q) begin
                        state_q <= FINISH;
                    end else begin
                        epoch_index_q  <= epoch_index_q + 32'd1;
                        sample_index_q <= '0;
                        state_q        <= WAIT_CREDIT;
                    end
                end
                WAIT_CREDIT: begin
                    if (avail_d == 8'd0) begin
                        state_q <= WAIT_CREDIT;
                    end else if (avail_d > CREDIT_MAX) begin
                        error_q <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        consumed_q <= consumed_q + 8'd1;
                        chunk_q    <= '0;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_d) begin
                        x_rd_en_q <= 1'b1;
                        rd_last_q <= last_chunk_d;
                        chunk_q   <= chunk_q + 1'b1;
                        if (last_chunk_d) state_q <= GROUP_END;
                    end
                end
                GROUP_END: begin
                    sample_index_q <= sample_index_d;
                    if (sample_index_d >= samples_q) state_q <= EPOCH;
                    else                              state_q <= WAIT_CREDIT;
                end
                FINISH: begin
                    done_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read address follows the chunk index of each issued read.
    always_ff @(posedge clk) begin
        if (issue_d) x_rd_addr_q <= DIS_X_BIT_DEPTH'(chunk_q);
    end

    // Register BRAM read data once on its way out.
    always_ff @(posedge clk) begin
        x_out_data_q <= x_rd_data;
    end

    sgd_valid_pipe #(
        .DEPTH (RD_LATENCY + 1),
        .WIDTH (2)
    ) u_valid_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  ({rd_last_q, x_rd_en_q}),
        .out_o (pipe_out)
    );

    assign x_rd_en     = x_rd_en_q;
    assign x_rd_addr   = x_rd_addr_q;
    assign x_out_valid = pipe_out[0];
    assign x_out_last  = pipe_out[1];
    assign x_out_data  = x_out_data_q;
    assign x_rd_done   = done_q;
    assign x_rd_error  = error_q;

`ifdef SGD_X_RD_DEBUG_EN
    logic [31:0] x_rd_counter_q;

    // Count every issued BRAM read.
    always_ff @(posedge clk) begin
        if (!rst_n)         x_rd_counter_q <= '0;
        else if (x_rd_en_q) x_rd_counter_q <= x_rd_counter_q + 32'd1;
    end

    assign x_rd_counter        = x_rd_counter_q;
    assign state_counters_x_rd = {x_rd_en_q, state_q, sample_index_q[19:0], epoch_index_q[7:0]};
`endif

endmodule

// File: tb/tb_sgd_x_rd.sv
// Scoreboard bench for sgd_x_rd: directed jobs push expected reads, a monitor
// checks addresses, returned data, last markers and output latency.
module tb_sgd_x_rd;
    import sgd_x_rd_pkg::*;

    localparam int RDL = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         started = 1'b0;
    logic [31:0]  dimension = '0, number_of_epochs = '0, number_of_samples = '0, mini_batch_size = 32'd8;
    logic [7:0]   credit = '0;
    logic         afull = 1'b0;
    logic         x_rd_en, x_out_valid, x_out_last, x_rd_done, x_rd_error;
    logic [11:0]  x_rd_addr;
    logic [255:0] x_rd_data, x_out_data;

    sgd_x_rd #(.RD_LATENCY(RDL)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .started             (started),
        .dimension           (dimension),
        .number_of_epochs    (number_of_epochs),
        .number_of_samples   (number_of_samples),
        .mini_batch_size     (mini_batch_size),
        .x_wr_credit_counter (credit),
        .x_rd_afull          (afull),
        .x_rd_en             (x_rd_en),
        .x_rd_addr           (x_rd_addr),
        .x_rd_data           (x_rd_data),
        .x_out_valid         (x_out_valid),
        .x_out_data          (x_out_data),
        .x_out_last          (x_out_last),
        .x_rd_done           (x_rd_done),
        .x_rd_error          (x_rd_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] pat(input logic [15:0] s, input logic [11:0] a);
        return {8{s, 4'h0, a}};
    endfunction

    typedef struct packed { logic last; logic [11:0] addr; } rd_exp_t;
    typedef struct packed { logic last; logic [255:0] data; } out_exp_t;
    rd_exp_t  rd_q[$];
    out_exp_t out_q[$];
    rd_exp_t  me;
    out_exp_t mo;

    int          rd_cnt  = 0;
    int          vld_cnt = 0;
    logic [15:0] mon_seq = '0;
    logic [RDL:0] en_hist = '0;

    // BRAM model: data identifies the read sequence number and address.
    logic [27:0] bram_pipe [RDL];
    logic [15:0] bram_seq = '0;
    always @(posedge clk) begin
        bram_pipe[0] <= {bram_seq, x_rd_addr};
        for (int i = 1; i < RDL; i++) bram_pipe[i] <= bram_pipe[i-1];
        if (x_rd_en) bram_seq <= bram_seq + 16'd1;
    end
    assign x_rd_data = pat(bram_pipe[RDL-1][27:12], bram_pipe[RDL-1][11:0]);

    // Monitor: pops expectations whenever the DUT reads or presents a chunk.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            en_hist = '0;
        end else begin
            if (x_out_valid || en_hist[RDL]) chk("out_latency", x_out_valid, en_hist[RDL]);
            en_hist = {en_hist[RDL-1:0], x_rd_en};
        end
        if (x_rd_en) begin
            rd_cnt++;
            if (rd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected: got addr=%0h want no read", x_rd_addr);
            end else begin
                me = rd_q.pop_front();
                chk("rd_addr", x_rd_addr, me.addr);
                out_q.push_back('{last: me.last, data: pat(mon_seq, me.addr)});
            end
            mon_seq++;
        end
        if (x_out_valid) begin
            vld_cnt++;
            if (out_q.size() == 0) begin
                total++; bad++;
                $display("FAIL vld_unexpected: got valid data=%0h want none", x_out_data);
            end else begin
                mo = out_q.pop_front();
                chk("out_data", x_out_data, mo.data);
                chk("out_last", x_out_last, mo.last);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        started = 1'b0;
        afull   = 1'b0;
        repeat (3) @(negedge clk);
        rd_q.delete();
        out_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic push_group(input int mc);
        for (int c = 0; c < mc; c++) rd_q.push_back('{last: (c == mc - 1), addr: 12'(c)});
    endtask

    task automatic setup(input int dim, input int samp, input int ep, input logic [7:0] cr);
        dimension         = dim;
        number_of_samples = samp;
        number_of_epochs  = ep;
        credit            = cr;
    endtask

    task automatic wait_done(input string nm, input int bound);
        for (int i = 0; i < bound && !x_rd_done; i++) @(negedge clk);
        chk({nm, "_done"}, x_rd_done, 1'b1);
    endtask

    task automatic wait_rd(input string nm, input int target, input int bound);
        for (int i = 0; i < bound && rd_cnt < target; i++) @(negedge clk);
        chk(nm, rd_cnt, target);
    endtask

    task automatic chk_drained(input string nm);
        chk({nm, "_rdq_left"}, rd_q.size(), 0);
        chk({nm, "_outq_left"}, out_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, vbase, k;

        // Reset state and basic job: 2 chunks per group, 2 groups.
        do_reset();
        cycles(1);
        chk("rst_en", x_rd_en, 1'b0);
        chk("rst_valid", x_out_valid, 1'b0);
        chk("rst_last", x_out_last, 1'b0);
        chk("rst_done", x_rd_done, 1'b0);
        chk("rst_error", x_rd_error, 1'b0);
        setup(1024, 16, 1, 8'd2);
        push_group(2); push_group(2);
        base = rd_cnt; vbase = vld_cnt;
        started = 1'b1;
        wait_done("t1", 200);
        cycles(8);
        chk("t1_reads", rd_cnt - base, 4);
        chk("t1_valids", vld_cnt - vbase, 4);
        chk("t1_error", x_rd_error, 1'b0);
        chk_drained("t1");

        // Credit starvation then a single credit step.
        do_reset();
        setup(512, 8, 1, 8'd0);
        push_group(1);
        base = rd_cnt;
        started = 1'b1;
        cycles(100);
        chk("t2_no_rd_while_starved", rd_cnt - base, 0);
        credit = 8'd1;
        k = 99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rd_cnt > base) begin k = i; break; end
        end
        chk("t2_first_rd_within_3", (k <= 3), 1'b1);
        wait_done("t2", 100);
        cycles(8);
        chk("t2_reads", rd_cnt - base, 1);
        chk_drained("t2");

        // Credit counter wrapping 255 -> 0 over 256 one-chunk groups.
        do_reset();
        setup(512, 2048, 1, 8'd100);
        repeat (256) push_group(1);
        base = rd_cnt;
        started = 1'b1;
        wait_rd("t3_reach_100", base + 100, 2000);
        cycles(5);
        chk("t3_hold_100", rd_cnt - base, 100);
        credit = 8'd200;
        wait_rd("t3_reach_200", base + 200, 2000);
        credit = 8'd255;
        wait_rd("t3_reach_255", base + 255, 2000);
        cycles(10);
        chk("t3_hold_255", rd_cnt - base, 255);
        credit = 8'd0;
        wait_done("t3", 200);
        cycles(8);
        chk("t3_reads", rd_cnt - base, 256);
        chk("t3_error", x_rd_error, 1'b0);
        chk_drained("t3");

        // Back-pressure toggling every cycle, 4 chunks, 2 epochs.
        do_reset();
        setup(2048, 16, 2, 8'd4);
        repeat (4) push_group(4);
        base = rd_cnt; vbase = vld_cnt;
        started = 1'b1;
        for (int i = 0; i < 400 && !x_rd_done; i++) begin
            @(negedge clk);
            afull = ~afull;
        end
        afull = 1'b0;
        chk("t4_done", x_rd_done, 1'b1);
        cycles(8);
        chk("t4_reads", rd_cnt - base, 16);
        chk("t4_valids", vld_cnt - vbase, 16);
        chk("t4_error", x_rd_error, 1'b0);
        chk_drained("t4");

        // Zero dimension is a configuration error with no reads.
        do_reset();
        setup(0, 16, 1, 8'd2);
        base = rd_cnt;
        started = 1'b1;
        wait_done("t5", 50);
        chk("t5_error", x_rd_error, 1'b1);
        cycles(5);
        chk("t5_reads", rd_cnt - base, 0);

        // Credit runaway (129 outstanding) is an error; 128 is accepted.
        do_reset();
        setup(512, 8, 1, 8'd129);
        base = rd_cnt;
        started = 1'b1;
        wait_done("t6", 50);
        chk("t6_error", x_rd_error, 1'b1);
        chk("t6_reads", rd_cnt - base, 0);

        do_reset();
        setup(512, 1024, 1, 8'd128);
        repeat (128) push_group(1);
        base = rd_cnt;
        started = 1'b1;
        wait_done("t6b", 1500);
        cycles(8);
        chk("t6b_error", x_rd_error, 1'b0);
        chk("t6b_reads", rd_cnt - base, 128);
        chk_drained("t6b");

        // Reset in the middle of issuing a group.
        do_reset();
        setup(2048, 16, 1, 8'd2);
        push_group(4); push_group(4);
        base = rd_cnt;
        started = 1'b1;
        for (int i = 0; i < 100 && rd_cnt == base; i++) @(negedge clk);
        chk("t7_first_rd", rd_cnt - base, 1);
        vbase = vld_cnt;
        rst_n   = 1'b0;
        started = 1'b0;
        @(negedge clk);
        chk("t7_rst_en", x_rd_en, 1'b0);
        chk("t7_rst_valid", x_out_valid, 1'b0);
        chk("t7_rst_last", x_out_last, 1'b0);
        chk("t7_rst_done", x_rd_done, 1'b0);
        chk("t7_rst_error", x_rd_error, 1'b0);
        rd_q.delete();
        out_q.delete();
        cycles(3);
        rst_n = 1'b1;
        cycles(10);
        chk("t7_no_late_valid", vld_cnt - vbase, 0);
        chk("t7_reads", rd_cnt - base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sgd_x_rd.md
SGD_X_RD -- requirements
Module: sgd_x_rd

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 2, meaning x BRAM read latency in cycles from x_rd_en to x_rd_data.
REQ-002 SHALL have parameter MAX_DIMENSION_BITS, default `MAX_BIT_WIDTH_OF_X, meaning the maximum model dimension width.
REQ-003 SHALL have ports (clock and reset first; reset rst_n, synchronous, active-low; clock clk):
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- started  in  1  job start level.
- dimension  in  32  model features.
- number_of_epochs  in  32  epochs.
- number_of_samples  in  32  samples per epoch.
- mini_batch_size  in  32  samples per batch.
- x_wr_credit_counter  in  8  cumulative sample-group credits from the model writer; wraps modulo 256.
- x_rd_afull  in  1  downstream almost-full; blocks new read issue.
- x_rd_en  out  1  BRAM read strobe.
- x_rd_addr  out  `DIS_X_BIT_DEPTH  BRAM chunk address.
- x_rd_data  in  `NUM_BITS_PER_BANK*32  BRAM read data.
- x_out_valid  out  1  model chunk valid.
- x_out_data  out  `NUM_BITS_PER_BANK*32  model chunk.
- x_out_last  out  1  last chunk of a sample group.
- x_rd_done  out  1  all epochs read.
- x_rd_error  out  1  configuration or credit error.

Function
REQ-004 SHALL register all configuration inputs once and compute main_counter = ceil(dimension / 2^(`BIT_WIDTH_OF_BANK+`ENGINE_NUM_WIDTH)) in 12 bits.
REQ-005 SHALL implement states IDLE, START, EPOCH, WAIT_CREDIT, ISSUE, GROUP_END, FINISH.
REQ-006 IDLE->START SHALL occur 2 cycles after started rises, via a 2-flop delay.
REQ-007 START SHALL clear epoch_index, sample_index, consumed counter and x_rd_error, then go to EPOCH.
REQ-007a START SHALL instead set x_rd_error and go to FINISH when main_counter == 0.
REQ-008 EPOCH SHALL go to FINISH when epoch_index == number_of_epochs. Otherwise it SHALL increment epoch_index, clear sample_index and go to WAIT_CREDIT.
REQ-009 WAIT_CREDIT SHALL compute avail = x_wr_credit_counter - consumed (8-bit wrap).
REQ-009a WAIT_CREDIT SHALL stay while avail == 0.
REQ-009b WAIT_CREDIT SHALL set x_rd_error and go to FINISH when avail > 128.
REQ-009c Otherwise WAIT_CREDIT SHALL increment consumed, clear chunk index and go to ISSUE.
REQ-010 ISSUE SHALL assert x_rd_en with x_rd_addr = chunk index only in cycles where x_rd_afull == 0. The chunk index SHALL advance per issued read.
REQ-010a ISSUE SHALL go to GROUP_END after issuing chunk main_counter-1.
REQ-011 GROUP_END SHALL add `NUM_OF_BANKS to sample_index.
REQ-011a GROUP_END SHALL go to EPOCH when the new sample_index >= number_of_samples, else to WAIT_CREDIT.
REQ-012 x_out_valid, x_out_data and x_out_last SHALL follow their x_rd_en issue by exactly RD_LATENCY+1 cycles. x_out_data SHALL be x_rd_data registered once. x_out_last SHALL mark chunk main_counter-1.
REQ-013 Credit arriving in the same cycle as its consumption SHALL be honoured on the next WAIT_CREDIT evaluation; no credit SHALL be lost across 8-bit wrap.
REQ-014 x_rd_done SHALL assert in FINISH and hold until reset. FINISH SHALL be absorbing.
REQ-015 x_rd_afull assertion mid-group SHALL pause issue without dropping or duplicating addresses.

Reset
REQ-016 Reset SHALL force state IDLE and clear x_rd_en, x_out_valid, x_out_last, x_rd_done, x_rd_error, consumed and the started delay flops.
REQ-016a Reset SHALL flush the valid pipeline so that no x_out_valid fires after a mid-group reset.
REQ-017 Data and address registers SHALL NOT require reset.

Configuration
REQ-018 With SGD_X_RD_DEBUG_EN defined, the block SHALL add output state_counters_x_rd[31:0] = {x_rd_en, state[2:0], sample_index[19:0], epoch_index[7:0]}.
REQ-018a With SGD_X_RD_DEBUG_EN defined, the block SHALL add output x_rd_counter[31:0], which counts x_rd_en pulses and is reset to 0.
REQ-018b Without SGD_X_RD_DEBUG_EN, these ports and their logic SHALL be absent.

Structure
REQ-019 State encodings and RD_LATENCY default SHALL live in the shared sgd package, alongside the existing widths from sgd_defines.vh.
REQ-020 The valid/last delay line SHALL be sub-module sgd_valid_pipe, parameterised by depth.

Verification
REQ-021 Setup: dimension=1024 (main_counter=2 at 512/chunk), samples=16, epochs=1, credit preset to 2 -> exactly 4 reads at addresses 0,1,0,1, x_out_last on reads 2 and 4, then x_rd_done.
REQ-022 Credit held at 0 for 100 cycles, then stepped to 1 -> no x_rd_en for those 100 cycles; the first x_rd_en occurs within 3 cycles of the step.
REQ-023 Consumed=255 and credit stepping 255->0 -> one group is read; no x_rd_error.
REQ-024 x_rd_afull toggled every other cycle during ISSUE -> the address sequence is intact and x_out_valid count equals the x_rd_en count.
REQ-025 dimension=0 -> x_rd_error=1 and x_rd_done=1 with zero reads.
REQ-026 rst_n pulsed mid-ISSUE -> all outputs are 0 the next cycle and no late x_out_valid occurs.
